// File: rtl/sh_mem_rr_arb.sv
// Shared data memory behind a round-robin arbiter: one access in flight,
// the served port gets a single-cycle ready pulse when its access completes.
module sh_mem_rr_arb #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [2*NUM_PORTS-1:0]                             enable,
  input  logic [ADDR_W*NUM_PORTS-1:0]                        addr,
  input  logic [DATA_W*NUM_PORTS-1:0]                        wr_data,
  output logic [DATA_W*NUM_PORTS-1:0]                        rd_data,
  output logic [NUM_PORTS-1:0]                               ready,
  output logic                                               busy,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id
);

  localparam int unsigned GID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  state_e              state_q, state_nxt;
  logic [GID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [NUM_PORTS-1:0] req_c;
  logic                 found_c;
  logic [GID_W-1:0]     win_c;
  int unsigned          arb_idx;
  logic [1:0]           win_op_c;
  logic                 done_c;
  logic                 in_range_c;
  logic                 mem_we_c;
  logic [DATA_W-1:0]    mem_rd_c;
  logic                 busy_nxt;
  logic [NUM_PORTS-1:0] ready_nxt;

  // Only 01 (read) and 10 (write) count as requests; 11 is reserved.
  always_comb begin
    req_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req_c[i] = (enable[2*i +: 2] == 2'b01) || (enable[2*i +: 2] == 2'b10);
    end
  end

  // First requester at or above ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    arb_idx = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      arb_idx = 32'(ptr_q) + k;
      if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
      if (!found_c && req_c[GID_W'(arb_idx)]) begin
        found_c = 1'b1;
        win_c   = GID_W'(arb_idx);
      end
    end
  end

  assign win_op_c   = enable[32'(win_c)*2 +: 2];
  assign done_c     = (state_q == ST_BUSY) && (cnt_q == '0);
  assign in_range_c = 32'(addr_q) < DEPTH;
  assign mem_rd_c   = in_range_c ? mem[MEM_AW'(addr_q)] : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (found_c) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt  = (state_nxt != ST_IDLE);
    ready_nxt = '0;
    mem_we_c  = 1'b0;
    if (done_c) begin
      ready_nxt[grant_id] = 1'b1;
      mem_we_c            = we_q && in_range_c && !reset;
    end
  end

  // Request latch, latency counter, read capture and pointer rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_id <= '0;
      rd_data  <= '0;
      ready    <= '0;
      busy     <= 1'b0;
    end else begin
      ready <= ready_nxt;
      busy  <= busy_nxt;
      case (state_q)
        ST_IDLE: begin
          if (found_c) begin
            grant_id <= win_c;
            we_q     <= (win_op_c == 2'b10);
            addr_q   <= addr[32'(win_c)*ADDR_W +: ADDR_W];
            wdata_q  <= wr_data[32'(win_c)*DATA_W +: DATA_W];
            cnt_q    <= CNT_W'(RD_LATENCY - 1);
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!we_q) begin
            rd_data[32'(grant_id)*DATA_W +: DATA_W] <= mem_rd_c;
          end
        end
        ST_RESP: begin
          ptr_q <= (32'(grant_id) == NUM_PORTS - 1) ? '0 : GID_W'(32'(grant_id) + 1);
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; an access cut short by reset never commits.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[MEM_AW'(addr_q)] <= wdata_q;
  end

endmodule

// File: tb/tb_sh_mem_rr_arb.sv
// Bench for sh_mem_rr_arb: table of single-port accesses, arbitration and
// reset sequences, with a ready-driven scoreboard on the main instance.
module tb_sh_mem_rr_arb;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [2*NP-1:0]   en, en3;
  logic [AW*NP-1:0]  ad, ad3;
  logic [DW*NP-1:0]  wd, wd3, rd, rd3;
  logic [NP-1:0]     rdy, rdy3;
  logic              bsy, bsy3;
  logic [1:0]        gid, gid3;

  sh_mem_rr_arb #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .enable(en), .addr(ad), .wr_data(wd),
    .rd_data(rd), .ready(rdy), .busy(bsy), .grant_id(gid));

  sh_mem_rr_arb #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .enable(en3), .addr(ad3), .wr_data(wd3),
    .rd_data(rd3), .ready(rdy3), .busy(bsy3), .grant_id(gid3));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for ready (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int         port;
    bit         is_rd;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [DW*NP-1:0] exp_bus = '0;

  // Every ready pulse on the main instance must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rdy != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(rdy), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("ready_port", 32'(rdy), 32'(1) << mon_e.port);
        check("ready_cycle", 32'(cyc), 32'(mon_e.due));
        check("grant_id", 32'(gid), 32'(mon_e.port));
        if (mon_e.is_rd) exp_bus[mon_e.port*DW +: DW] = mon_e.data;
        check("rd_data_bus", 32'(rd), 32'(exp_bus));
      end
    end
  end

  task automatic wait_ready(input int p, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (rdy[p] === 1'b1) ok = 1'b1;
    end
    if (!ok) timeout($sformatf("wait_ready_p%0d", p));
  endtask

  task automatic txn(input int p, input bit is_rd, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] exp_d);
    bit ok;
    @(negedge clk);
    en[p*2 +: 2]  = is_rd ? 2'b01 : 2'b10;
    ad[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
    exp_q.push_back('{port: p, is_rd: is_rd, data: exp_d, due: cyc + 2});
    wait_ready(p, ok);
    en[p*2 +: 2] = 2'b00;
  endtask

  task automatic txn3(input int p, input bit is_rd, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_d);
    int start;
    int n = 0;
    @(negedge clk);
    en3[p*2 +: 2]  = is_rd ? 2'b01 : 2'b10;
    ad3[p*AW +: AW] = a;
    wd3[p*DW +: DW] = d;
    start = cyc;
    while (rdy3[p] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    en3[p*2 +: 2] = 2'b00;
    if (rdy3[p] !== 1'b1) begin
      timeout("lat3_ready");
    end else begin
      check("lat3_cycle", 32'(cyc), 32'(start + 4));
      if (is_rd) check("lat3_rd_data", 32'(rd3[p*DW +: DW]), 32'(exp_d));
    end
  endtask

  typedef struct {
    int         port;
    bit         is_rd;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          seen;
    int          n;
    logic [3:0]  pend;
    int          c;

    vecs[0]  = '{0, 1'b0, 8'h10, 8'hA5, 8'h00};
    vecs[1]  = '{0, 1'b1, 8'h10, 8'h00, 8'hA5};
    vecs[2]  = '{1, 1'b0, 8'h32, 8'h3C, 8'h00};
    vecs[3]  = '{2, 1'b0, 8'hFA, 8'h55, 8'h00};
    vecs[4]  = '{2, 1'b1, 8'hFA, 8'h00, 8'h00};
    vecs[5]  = '{1, 1'b0, 8'hC7, 8'hC7, 8'h00};
    vecs[6]  = '{0, 1'b0, 8'hC8, 8'hEE, 8'h00};
    vecs[7]  = '{0, 1'b1, 8'hC8, 8'h00, 8'h00};
    vecs[8]  = '{2, 1'b1, 8'h10, 8'h00, 8'hA5};
    vecs[9]  = '{1, 1'b0, 8'h10, 8'h5A, 8'h00};
    vecs[10] = '{1, 1'b1, 8'h10, 8'h00, 8'h5A};
    vecs[11] = '{3, 1'b1, 8'h32, 8'h00, 8'h3C};
    vecs[12] = '{3, 1'b1, 8'hC7, 8'h00, 8'hC7};

    reset = 1'b1;
    en = '0; ad = '0; wd = '0;
    en3 = '0; ad3 = '0; wd3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_rd_data", 32'(rd), 32'(0));
    check("reset_ready", 32'(rdy), 32'(0));
    check("reset_busy", 32'(bsy), 32'(0));
    check("reset_grant_id", 32'(gid), 32'(0));
    check("reset_busy3", 32'(bsy3), 32'(0));

    // Reserved opcode on every port is not a request.
    en = '1;
    repeat (10) begin
      @(negedge clk);
      check("reserved_busy", 32'(bsy), 32'(0));
      check("reserved_ready", 32'(rdy), 32'(0));
    end
    en = '0;

    // All ports write together with ptr at 0: served 0,1,2,3.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      en[i*2 +: 2]  = 2'b10;
      ad[i*AW +: AW] = 8'(i);
      wd[i*DW +: DW] = 8'(i);
      exp_q.push_back('{port: i, is_rd: 1'b0, data: 8'h00, due: cyc + 2 + 3*i});
    end
    pend = 4'hF;
    n = 0;
    while (pend != 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] === 1'b1) begin
          en[i*2 +: 2] = 2'b00;
          pend[i] = 1'b0;
        end
      end
    end
    if (pend != 4'h0) timeout("all_ports_write");
    en = '0;
    for (int i = 0; i < 4; i++) txn(i, 1'b1, 8'(i), 8'h00, 8'(i));

    for (int v = 0; v < 13; v++) txn(vecs[v].port, vecs[v].is_rd, vecs[v].a, vecs[v].d, vecs[v].exp_d);

    // Port 3 served last; ports 1 and 3 then request back to back.
    @(negedge clk);
    en[1*2 +: 2] = 2'b01; ad[1*AW +: AW] = 8'h32;
    en[3*2 +: 2] = 2'b01; ad[3*AW +: AW] = 8'hC7;
    c = cyc;
    exp_q.push_back('{port: 1, is_rd: 1'b1, data: 8'h3C, due: c + 2});
    exp_q.push_back('{port: 3, is_rd: 1'b1, data: 8'hC7, due: c + 5});
    exp_q.push_back('{port: 1, is_rd: 1'b1, data: 8'h3C, due: c + 8});
    exp_q.push_back('{port: 3, is_rd: 1'b1, data: 8'hC7, due: c + 11});
    seen = 0;
    n = 0;
    while (seen < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[1] === 1'b1 || rdy[3] === 1'b1) seen++;
    end
    en = '0;
    if (seen < 4) timeout("alternate_1_3");
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    // Longer latency: a write cut off by reset mid-BUSY never lands.
    txn3(1, 1'b0, 8'h40, 8'h11, 8'h00);
    txn3(1, 1'b1, 8'h40, 8'h00, 8'h11);
    @(negedge clk);
    en3[1*2 +: 2] = 2'b10; ad3[1*AW +: AW] = 8'h40; wd3[1*DW +: DW] = 8'h99;
    @(negedge clk);
    check("lat3_busy_first", 32'(bsy3), 32'(1));
    @(negedge clk);
    check("lat3_busy_second", 32'(bsy3), 32'(1));
    reset = 1'b1;
    en3 = '0;
    @(negedge clk);
    check("abort_busy", 32'(bsy3), 32'(0));
    check("abort_ready", 32'(rdy3), 32'(0));
    check("abort_rd_data", 32'(rd3), 32'(0));
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_ready", 32'(rdy3), 32'(0));
    end
    txn3(1, 1'b1, 8'h40, 8'h00, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
